fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer:
//   - state_e        : FSM state encoding (BOOT=0, RUN=1, STALL=2, HALT=3)
//   - INSTR_SIZE     : byte distance between sequential instructions
//   - RESET_VECTOR_DEFAULT : default boot / reset PC
//   - is_misaligned  : true when an address is not word aligned
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] INSTR_SIZE           = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // A fetch target must be word aligned; any set bit in [1:0] is illegal.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Selects the next PC each cycle and produces pipeline flush controls.
// The PC register itself lives outside this block.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   PC                : current PC from the external PC register
//   stall_F           : fetch stall request from the hazard unit
//   PCSrc_E           : taken branch/jump resolved in EX
//   PCTarget_E        : redirect target from EX
//   halt_req          : enter HALT (ecall/ebreak decode)
//   resume            : leave HALT
//   PC_Next           : value loaded into the PC register every cycle
//   flush_D / flush_E : clear IF/ID and ID/EX registers
//   fetch_valid       : instruction fetched at PC this cycle is architectural
//   misalign_err      : sticky flag, set by a misaligned redirect target
//   state             : FSM state (BOOT=0, RUN=1, STALL=2, HALT=3)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        stall_F,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] PC_Next,
  output logic        flush_D,
  output logic        flush_E,
  output logic        fetch_valid,
  output logic        misalign_err,
  output logic [1:0]  state
);

  // Counter value on the last BOOT cycle.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic        misalign_err_q, misalign_err_d;

  logic [31:0] pc_seq_s;
  logic        redirect_bad_s;

  // 32-bit add wraps naturally modulo 2^32.
  assign pc_seq_s       = PC + INSTR_SIZE;
  assign redirect_bad_s = PCSrc_E && is_misaligned(PCTarget_E);

  assign state        = state_q;
  assign misalign_err = misalign_err_q;

  // State, boot counter and sticky error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BOOT;
      boot_cnt_q     <= 4'd0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      boot_cnt_q     <= boot_cnt_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Next-state logic; priority in RUN/STALL is
  // misaligned redirect > redirect > halt_req > stall_F > sequential.
  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    misalign_err_d = misalign_err_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      ST_RUN, ST_STALL: begin
        if (redirect_bad_s) begin
          state_d        = ST_HALT;
          misalign_err_d = 1'b1;
        end else if (PCSrc_E) begin
          state_d = ST_RUN;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (stall_F) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // Redirects and stalls are ignored; resume beats a concurrent halt_req.
        if (resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = 4'd0;
      end
    endcase
  end

  // Output logic; reset overrides everything combinationally.
  always_comb begin
    PC_Next     = PC;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    fetch_valid = 1'b0;
    if (rst) begin
      PC_Next = RESET_VECTOR;
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          PC_Next = RESET_VECTOR;
          flush_D = 1'b1;
          flush_E = 1'b1;
        end
        ST_RUN, ST_STALL: begin
          if (redirect_bad_s) begin
            PC_Next = PC;
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (PCSrc_E) begin
            PC_Next = PCTarget_E;
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (halt_req) begin
            PC_Next = PC;
            flush_D = 1'b1;
          end else if (stall_F) begin
            PC_Next = PC;
          end else begin
            PC_Next     = pc_seq_s;
            fetch_valid = 1'b1;
          end
        end
        ST_HALT: begin
          // Resuming steps past the halting instruction.
          flush_D = 1'b1;
          if (resume) begin
            PC_Next = pc_seq_s;
          end else begin
            PC_Next = PC;
          end
        end
        default: begin
          PC_Next = RESET_VECTOR;
          flush_D = 1'b1;
          flush_E = 1'b1;
        end
      endcase
    end
  end

endmodule
